// File: rtl/fnd_scan_decoder.sv
// Readback decoder for the multiplexed 4-digit 7-segment bus: waits for each strobe
// to settle, decodes the pattern back to BCD and publishes complete frames.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_WAIT    | no digit strobe selected on the sampled bus
// ST_SETTLE  | valid strobe seen, counting identical samples
// ST_CAPTURE | digit written to shadow on the edge that entered this state
// ST_HOLD    | dwell already captured, waiting for the bus to change
module fnd_scan_decoder #(
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  fnd_com,
    input  logic [7:0]  fnd_data,
    output logic [15:0] digits,
    output logic [3:0]  dp_out,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        stale
);
    localparam int CW = $clog2(SETTLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] SETTLE_N  = CW'(SETTLE_CYC);
    localparam logic [TW-1:0] TIMEOUT_N = TW'(TIMEOUT_CYC);

    typedef enum logic [1:0] {ST_WAIT, ST_SETTLE, ST_CAPTURE, ST_HOLD} state_t;

    state_t          state_q, state_d;
    logic [3:0]      com_q;
    logic [7:0]      data_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   to_q, to_d;
    logic [3:0]      seen_q, seen_d;
    logic [3:0][3:0] shd_nib_q, shd_nib_d;
    logic [3:0]      shd_dp_q, shd_dp_d;
    logic [3:0]      shd_err_q, shd_err_d;
    logic [15:0]     digits_q, digits_d;
    logic [3:0]      dp_q, dp_d;
    logic            fv_q, fv_d;
    logic            ferr_q, ferr_d;
    logic            stale_q, stale_d;

    logic            nxt_valid, nxt_same, capture, frame_load, to_hit;
    logic [1:0]      idx;
    logic [3:0]      nib;
    logic            dec_err;

    always_comb begin
        nxt_valid = (fnd_com == 4'b1110) || (fnd_com == 4'b1101) ||
                    (fnd_com == 4'b1011) || (fnd_com == 4'b0111);
        nxt_same  = ({fnd_com, fnd_data} == {com_q, data_q});

        // Counter tracks the value being loaded into com_q/data_q this edge.
        if (!nxt_valid)
            cnt_d = '0;
        else if (!nxt_same)
            cnt_d = CW'(1);
        else if (cnt_q == SETTLE_N)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + CW'(1);

        state_d = state_q;
        capture = 1'b0;
        if (!nxt_valid) begin
            state_d = ST_WAIT;
        end else begin
            case (state_q)
                ST_WAIT:   state_d = ST_SETTLE;
                ST_SETTLE: begin
                    if (cnt_d == SETTLE_N) begin
                        state_d = ST_CAPTURE;
                        capture = 1'b1;
                    end
                end
                default:   state_d = nxt_same ? ST_HOLD : ST_SETTLE;
            endcase
        end

        case (com_q)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase

        dec_err = 1'b0;
        case (data_q[6:0])
            7'h40:   nib = 4'h0;
            7'h79:   nib = 4'h1;
            7'h24:   nib = 4'h2;
            7'h30:   nib = 4'h3;
            7'h19:   nib = 4'h4;
            7'h12:   nib = 4'h5;
            7'h02:   nib = 4'h6;
            7'h78:   nib = 4'h7;
            7'h00:   nib = 4'h8;
            7'h10:   nib = 4'h9;
            7'h7F:   nib = 4'hB;
            default: begin
                nib     = 4'hF;
                dec_err = 1'b1;
            end
        endcase

        // Reload to 1 the cycle after a capture: the counter means "cycles since capture".
        if (state_q == ST_CAPTURE)
            to_d = TW'(1);
        else if (to_q == TIMEOUT_N)
            to_d = to_q;
        else
            to_d = to_q + TW'(1);
        to_hit  = (to_d == TIMEOUT_N) && (to_q != TIMEOUT_N);
        stale_d = (to_d == TIMEOUT_N);

        frame_load = (seen_q == 4'hF);
        seen_d     = seen_q;
        shd_nib_d  = shd_nib_q;
        shd_dp_d   = shd_dp_q;
        shd_err_d  = shd_err_q;
        if (frame_load || to_hit)
            seen_d = '0;
        if (frame_load)
            shd_err_d = '0;
        if (capture) begin
            seen_d[idx]    = 1'b1;
            shd_nib_d[idx] = nib;
            shd_dp_d[idx]  = ~data_q[7];
            shd_err_d[idx] = dec_err;
        end

        digits_d = frame_load ? shd_nib_q  : digits_q;
        dp_d     = frame_load ? shd_dp_q   : dp_q;
        ferr_d   = frame_load ? |shd_err_q : ferr_q;
        fv_d     = frame_load;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_WAIT;
            com_q     <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            to_q      <= '0;
            seen_q    <= '0;
            shd_nib_q <= '0;
            shd_dp_q  <= '0;
            shd_err_q <= '0;
            digits_q  <= '0;
            dp_q      <= '0;
            fv_q      <= 1'b0;
            ferr_q    <= 1'b0;
            stale_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            com_q     <= fnd_com;
            data_q    <= fnd_data;
            cnt_q     <= cnt_d;
            to_q      <= to_d;
            seen_q    <= seen_d;
            shd_nib_q <= shd_nib_d;
            shd_dp_q  <= shd_dp_d;
            shd_err_q <= shd_err_d;
            digits_q  <= digits_d;
            dp_q      <= dp_d;
            fv_q      <= fv_d;
            ferr_q    <= ferr_d;
            stale_q   <= stale_d;
        end
    end

    assign digits      = digits_q;
    assign dp_out      = dp_q;
    assign frame_valid = fv_q;
    assign frame_err   = ferr_q;
    assign stale       = stale_q;
endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Bench for fnd_scan_decoder: table of full scans, hand-written corner sequences,
// and a randomized segment stream checked against a dwell-level reference model.
module tb_fnd_scan_decoder;
    localparam int S = 4;
    localparam int T = 50;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  fnd_com = 4'hF;
    logic [7:0]  fnd_data = 8'hFF;
    logic [15:0] digits;
    logic [3:0]  dp_out;
    logic        frame_valid;
    logic        frame_err;
    logic        stale;

    fnd_scan_decoder #(.SETTLE_CYC(S), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .reset(reset), .fnd_com(fnd_com), .fnd_data(fnd_data),
        .digits(digits), .dp_out(dp_out), .frame_valid(frame_valid),
        .frame_err(frame_err), .stale(stale)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n++;

    typedef struct { int e; logic [15:0] d; logic [3:0] dp; logic err; } frame_t;
    typedef struct { logic [3:0] c; logic [7:0] d; int len; int start; } seg_t;
    typedef struct { logic [31:0] p; logic [15:0] dig; logic [3:0] dp; logic err; } vec_t;

    frame_t fq[$];
    seg_t   segs[$];
    int     st_e[$];
    bit     st_v[$];
    bit     log_on = 1'b0;
    bit     fv_prev = 1'b0;
    int     fv_double = 0;
    int     checks = 0;
    int     errors = 0;
    logic [6:0] seg7 [10];

    always @(negedge clk) begin
        frame_t f;
        if (frame_valid === 1'b1) begin
            f.e = edge_n; f.d = digits; f.dp = dp_out; f.err = frame_err;
            fq.push_back(f);
            if (fv_prev) fv_double++;
        end
        fv_prev = (frame_valid === 1'b1);
        if (log_on) begin
            st_e.push_back(edge_n);
            st_v.push_back(stale);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; the value occupies the next len posedges.
    task automatic seg(input logic [3:0] c, input logic [7:0] d, input int len);
        seg_t s;
        fnd_com = c; fnd_data = d;
        s.c = c; s.d = d; s.len = len; s.start = edge_n + 1;
        segs.push_back(s);
        repeat (len) @(negedge clk);
    endtask

    task automatic scan(input logic [31:0] p, input int dw, output int d3_start);
        seg(4'hE, p[7:0], dw);
        seg(4'hD, p[15:8], dw);
        seg(4'hB, p[23:16], dw);
        seg(4'h7, p[31:24], dw);
        d3_start = segs[$].start;
    endtask

    function automatic bit is_valid(input logic [3:0] c);
        return (c == 4'hE) || (c == 4'hD) || (c == 4'hB) || (c == 4'h7);
    endfunction

    function automatic int com_index(input logic [3:0] c);
        for (int i = 0; i < 4; i++) if (c[i] == 1'b0) return i;
        return 0;
    endfunction

    function automatic void decode(input logic [6:0] p, output logic [3:0] nib, output logic err);
        nib = 4'hF; err = 1'b1;
        if (p == 7'h7F) begin nib = 4'hB; err = 1'b0; end
        for (int i = 0; i < 10; i++)
            if (seg7[i] == p) begin nib = 4'(i); err = 1'b0; end
    endfunction

    initial begin
        vec_t       vt [5];
        int         d3s, e1, e2, c, r, ev, cap, idx, pi, mism;
        logic [3:0] rc, pc, mseen, nb;
        logic [7:0] rd, pd;
        logic [3:0] mnib [4];
        logic [3:0] mdp, merr;
        logic       er;
        int         len, sel;
        logic [3:0] vcom [4];
        frame_t     ef;
        frame_t     exp_q[$];

        seg7 = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        vcom = '{4'hE, 4'hD, 4'hB, 4'h7};
        vt[0] = '{32'hB0A4F9C0, 16'h3210, 4'b0000, 1'b0};
        vt[1] = '{32'hFF129299, 16'hB554, 4'b0100, 1'b0};
        vt[2] = '{32'h9080F882, 16'h9876, 4'b0000, 1'b0};
        vt[3] = '{32'hC0C0C055, 16'h000F, 4'b0001, 1'b1};
        vt[4] = '{32'h30247940, 16'h3210, 4'b1111, 1'b0};

        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_digits", 32'(digits), 32'h0);
        check("reset_dp", 32'(dp_out), 32'h0);
        check("reset_fv", 32'(frame_valid), 32'h0);
        check("reset_err", 32'(frame_err), 32'h0);
        check("reset_stale", 32'(stale), 32'h0);
        reset = 1'b1;

        for (int i = 0; i < 5; i++) begin
            fq.delete();
            scan(vt[i].p, 10, d3s);
            seg(4'hF, 8'hFF, 4);
            check($sformatf("row%0d_count", i), 32'(fq.size()), 32'd1);
            if (fq.size() > 0) begin
                check($sformatf("row%0d_edge", i), 32'(fq[0].e), 32'(d3s + S));
                check($sformatf("row%0d_digits", i), 32'(fq[0].d), 32'(vt[i].dig));
                check($sformatf("row%0d_dp", i), 32'(fq[0].dp), 32'(vt[i].dp));
                check($sformatf("row%0d_err", i), 32'(fq[0].err), 32'(vt[i].err));
            end
        end

        // Short wrong pattern before the real digit1 value.
        fq.delete();
        seg(4'hE, 8'hC0, 10); seg(4'hD, 8'h99, 3); seg(4'hD, 8'hF9, 10);
        seg(4'hB, 8'hA4, 10); seg(4'h7, 8'hB0, 10); seg(4'hF, 8'hFF, 4);
        check("glitch_data_count", 32'(fq.size()), 32'd1);
        if (fq.size() > 0) check("glitch_data_digits", 32'(fq[0].d), 32'h3210);

        // One-cycle double strobe splits digit1 into two short dwells.
        fq.delete();
        seg(4'hE, 8'hC0, 10); seg(4'hD, 8'hF9, 2); seg(4'hC, 8'hF9, 1); seg(4'hD, 8'hF9, 3);
        seg(4'hB, 8'hA4, 10); seg(4'h7, 8'hB0, 10); seg(4'hF, 8'hFF, 2);
        check("glitch_com_noframe", 32'(fq.size()), 32'd0);
        seg(4'hD, 8'hF9, 10);
        e1 = segs[$].start;
        seg(4'hF, 8'hFF, 4);
        check("glitch_com_count", 32'(fq.size()), 32'd1);
        if (fq.size() > 0) begin
            check("glitch_com_edge", 32'(fq[0].e), 32'(e1 + S));
            check("glitch_com_digits", 32'(fq[0].d), 32'h3210);
        end

        c = e1 + S - 1;
        seg(4'hF, 8'hFF, c + 49 - edge_n);
        check("stale_before", 32'(stale), 32'd0);
        seg(4'hF, 8'hFF, 1);
        check("stale_at_timeout", 32'(stale), 32'd1);

        fq.delete();
        seg(4'hE, 8'h92, 10); seg(4'hD, 8'h82, 10); seg(4'hF, 8'hFF, 60);
        check("stale_after_partial", 32'(stale), 32'd1);
        seg(4'hB, 8'hF8, 10);
        check("stale_cleared", 32'(stale), 32'd0);
        seg(4'h7, 8'h80, 10);
        check("partial_discarded", 32'(fq.size()), 32'd0);
        seg(4'hE, 8'h90, 10); seg(4'hD, 8'hC0, 10);
        e2 = segs[$].start;
        seg(4'hF, 8'hFF, 4);
        check("after_stale_count", 32'(fq.size()), 32'd1);
        if (fq.size() > 0) begin
            check("after_stale_edge", 32'(fq[0].e), 32'(e2 + S));
            check("after_stale_digits", 32'(fq[0].d), 32'h8709);
        end

        fq.delete();
        seg(4'hE, 8'hC0, 10); seg(4'hD, 8'hF9, 10); seg(4'hB, 8'hA4, 10);
        fnd_com = 4'hF; fnd_data = 8'hFF;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        seg(4'h7, 8'hB0, 10); seg(4'hF, 8'hFF, 4);
        check("midreset_noframe", 32'(fq.size()), 32'd0);
        check("midreset_digits", 32'(digits), 32'h0);
        check("midreset_dp", 32'(dp_out), 32'h0);
        check("midreset_err", 32'(frame_err), 32'h0);
        check("midreset_stale", 32'(stale), 32'h0);

        // Randomized stream against the dwell-level model.
        fnd_com = 4'hF; fnd_data = 8'hFF;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        r = edge_n;
        segs.delete(); fq.delete(); st_e.delete(); st_v.delete();
        log_on = 1'b1;
        pc = 4'hF; pd = 8'hFF;
        for (int i = 0; i < 200; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)       rc = vcom[$urandom_range(0, 3)];
            else if (sel == 7) rc = 4'hF;
            else               rc = 4'($urandom);
            sel = $urandom_range(0, 9);
            if (sel < 7)       rd = {1'($urandom), seg7[$urandom_range(0, 9)]};
            else if (sel == 7) rd = {1'($urandom), 7'h7F};
            else               rd = 8'($urandom);
            len = $urandom_range(1, 12);
            if (!is_valid(rc) && $urandom_range(0, 7) == 0) len = $urandom_range(45, 70);
            if ({rc, rd} == {pc, pd}) rd[0] = ~rd[0];
            seg(rc, rd, len);
            pc = rc; pd = rd;
        end
        seg(4'hF, 8'hFF, 6);
        log_on = 1'b0;

        ev = r; mseen = '0; mdp = '0; merr = '0;
        for (int i = 0; i < 4; i++) mnib[i] = '0;
        begin
            int caps[$];
            foreach (segs[i]) begin
                if (is_valid(segs[i].c) && segs[i].len >= S) begin
                    cap = segs[i].start + S - 1;
                    if (cap - ev >= T) mseen = '0;
                    idx = com_index(segs[i].c);
                    decode(segs[i].d[6:0], nb, er);
                    mseen[idx] = 1'b1; mnib[idx] = nb;
                    mdp[idx] = ~segs[i].d[7]; merr[idx] = er;
                    if (mseen == 4'hF) begin
                        ef.e = cap + 1; ef.d = {mnib[3], mnib[2], mnib[1], mnib[0]};
                        ef.dp = mdp; ef.err = |merr;
                        exp_q.push_back(ef);
                        mseen = '0;
                    end
                    caps.push_back(cap);
                    ev = cap;
                end
            end
            mism = 0; pi = 0; ev = r;
            foreach (st_e[i]) begin
                while (pi < caps.size() && caps[pi] < st_e[i]) begin
                    ev = caps[pi]; pi++;
                end
                if (st_v[i] != ((st_e[i] - ev) >= T)) mism++;
            end
        end
        check("rand_stale_mismatch_edges", 32'(mism), 32'd0);
        check("rand_frame_count", 32'(fq.size()), 32'(exp_q.size()));
        for (int i = 0; i < fq.size() && i < exp_q.size(); i++) begin
            check($sformatf("rand%0d_edge", i), 32'(fq[i].e), 32'(exp_q[i].e));
            check($sformatf("rand%0d_digits", i), 32'(fq[i].d), 32'(exp_q[i].d));
            check($sformatf("rand%0d_dp", i), 32'(fq[i].dp), 32'(exp_q[i].dp));
            check($sformatf("rand%0d_err", i), 32'(fq[i].err), 32'(exp_q[i].err));
        end
        check("fv_back_to_back", 32'(fv_double), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
